// File: rtl/dff_mon_pkg.sv
// Shared types and helpers for the register-bank compare monitor.
package dff_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAIL  = 2'd3
    } mon_state_t;

    // Widest vector the X/Z detector accepts; narrower inputs are zero-extended.
    localparam int XZ_W = 256;

    function automatic logic is_xz(input logic [XZ_W-1:0] v);
        return ((^v) === 1'bx);
    endfunction

endpackage

// File: rtl/dff_compare_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/dff_compare_monitor.sv
// Compares two register-bank outputs every clock with 4-state inequality and
// keeps saturating statistics, a first-failure capture and a sticky fail flag.
module dff_compare_monitor
    import dff_mon_pkg::*;
#(
    parameter int g_count     = 16,
    parameter int g_cnt_width = 16,
    parameter int g_warmup    = 2,
    parameter int g_max_err   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [g_count-1:0]     o_a,
    input  logic [g_count-1:0]     o_b,
    output logic                   mismatch,
    output logic                   fail,
    output logic [g_cnt_width-1:0] err_count,
    output logic [g_cnt_width-1:0] sample_count,
    output logic [g_count-1:0]     first_a,
    output logic [g_count-1:0]     first_b,
    output logic                   xz_seen,
    output logic [1:0]             state_o
);

    localparam int WARM_W = (g_warmup > 1) ? $clog2(g_warmup + 1) : 1;
    localparam logic [WARM_W-1:0]      WARM_INIT = WARM_W'(g_warmup);
    localparam logic [g_cnt_width-1:0] MAX_ERR   = g_cnt_width'(g_max_err);

    mon_state_t             state, state_next;
    logic [WARM_W-1:0]      warm, warm_next;
    logic [XZ_W-1:0]        a_ext, b_ext;
    logic                   sample, miss, budget_hit;
    logic [g_cnt_width-1:0] err_post;

    assign a_ext   = XZ_W'(o_a);
    assign b_ext   = XZ_W'(o_b);
    assign state_o = state;

    always_comb begin
        sample = (state == ST_RUN) && en && !clr;
        miss   = sample && (o_a !== o_b);
        // Budget is judged on the count as it will be after this sample.
        err_post   = (err_count == '1) ? err_count : err_count + g_cnt_width'(1);
        budget_hit = (g_max_err != 0) && miss && (err_post >= MAX_ERR);
    end

    always_comb begin
        state_next = state;
        warm_next  = warm;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    if (g_warmup == 0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_ARMED;
                        warm_next  = WARM_INIT;
                    end
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else begin
                    warm_next = warm - WARM_W'(1);
                    if (warm == WARM_W'(1)) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (budget_hit) begin
                    state_next = ST_FAIL;
                end
            end
            default: state_next = ST_FAIL;
        endcase
        if (clr) begin
            state_next = ST_IDLE;
            warm_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            warm     <= '0;
            mismatch <= 1'b0;
            fail     <= 1'b0;
            xz_seen  <= 1'b0;
            first_a  <= '0;
            first_b  <= '0;
        end else begin
            state    <= state_next;
            warm     <= warm_next;
            mismatch <= miss;
            fail     <= (state_next == ST_FAIL);
            if (clr) begin
                xz_seen <= 1'b0;
                first_a <= '0;
                first_b <= '0;
            end else begin
                if (sample && (is_xz(a_ext) || is_xz(b_ext))) begin
                    xz_seen <= 1'b1;
                end
                if (miss && (err_count == '0)) begin
                    first_a <= o_a;
                    first_b <= o_b;
                end
            end
        end
    end

    sat_counter #(.width(g_cnt_width)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (miss),
        .count (err_count)
    );

    sat_counter #(.width(g_cnt_width)) u_smp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (sample),
        .count (sample_count)
    );

endmodule

// File: tb/tb_dff_compare_monitor.sv
// Drives two monitor instances (budget 1 / 16-bit counters, budget 0 / 4-bit
// counters) from shared stimulus and checks them against a cycle model.
module tb_dff_compare_monitor;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [15:0] o_a, o_b;

    logic        mis_a, fail_a, xz_a;
    logic [15:0] err_a, smp_a, fa_a, fb_a;
    logic [1:0]  st_a;
    logic        mis_b, fail_b, xz_b;
    logic [3:0]  err_b, smp_b;
    logic [15:0] fa_b, fb_b;
    logic [1:0]  st_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_compare_monitor #(.g_count(16), .g_cnt_width(16), .g_warmup(2), .g_max_err(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .o_a(o_a), .o_b(o_b),
        .mismatch(mis_a), .fail(fail_a), .err_count(err_a), .sample_count(smp_a),
        .first_a(fa_a), .first_b(fb_a), .xz_seen(xz_a), .state_o(st_a)
    );

    dff_compare_monitor #(.g_count(16), .g_cnt_width(4), .g_warmup(2), .g_max_err(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .o_a(o_a), .o_b(o_b),
        .mismatch(mis_b), .fail(fail_b), .err_count(err_b), .sample_count(smp_b),
        .first_a(fa_b), .first_b(fb_b), .xz_seen(xz_b), .state_o(st_b)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        mis;
        logic        fail;
        logic        xz;
        logic [15:0] err;
        logic [15:0] smp;
        logic [15:0] fa;
        logic [15:0] fb;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, index 0 = u_dut_a, 1 = u_dut_b.
    int          m_state[2], m_warm[2], m_err[2], m_smp[2];
    logic [15:0] m_fa[2], m_fb[2];
    logic        m_xz[2], m_mis[2];
    int          p_cmax[2]   = '{65535, 15};
    int          p_budget[2] = '{1, 0};
    int          p_warmup    = 2;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_warm[k] = 0; m_err[k] = 0; m_smp[k] = 0;
            m_fa[k] = '0; m_fb[k] = '0; m_xz[k] = 1'b0; m_mis[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        m_mis[k] = 1'b0;
        if (clr) begin
            m_state[k] = 0; m_warm[k] = 0; m_err[k] = 0; m_smp[k] = 0;
            m_fa[k] = '0; m_fb[k] = '0; m_xz[k] = 1'b0;
            return;
        end
        case (m_state[k])
            0: if (en) begin
                if (p_warmup == 0) m_state[k] = 2;
                else begin m_state[k] = 1; m_warm[k] = p_warmup; end
            end
            1: if (!en) m_state[k] = 0;
               else begin
                   if (m_warm[k] == 1) m_state[k] = 2;
                   m_warm[k] = m_warm[k] - 1;
               end
            2: if (!en) m_state[k] = 0;
               else begin
                   if (m_smp[k] < p_cmax[k]) m_smp[k] = m_smp[k] + 1;
                   if ((^o_a === 1'bx) || (^o_b === 1'bx)) m_xz[k] = 1'b1;
                   if (o_a !== o_b) begin
                       m_mis[k] = 1'b1;
                       if (m_err[k] == 0) begin m_fa[k] = o_a; m_fb[k] = o_b; end
                       if (m_err[k] < p_cmax[k]) m_err[k] = m_err[k] + 1;
                       if (p_budget[k] != 0 && m_err[k] >= p_budget[k]) m_state[k] = 3;
                   end
               end
            default: ;
        endcase
    endtask

    function automatic exp_t snap(input int k);
        exp_t e;
        e.st = m_state[k][1:0]; e.mis = m_mis[k]; e.fail = (m_state[k] == 3);
        e.xz = m_xz[k]; e.err = m_err[k][15:0]; e.smp = m_smp[k][15:0];
        e.fa = m_fa[k]; e.fb = m_fb[k];
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_dut(input string who, input exp_t e, input logic [1:0] st,
                               input logic mis, input logic fl, input logic xz,
                               input logic [15:0] err, input logic [15:0] smp,
                               input logic [15:0] fa, input logic [15:0] fb);
        check({who, ".state"},        {14'd0, st},  {14'd0, e.st});
        check({who, ".mismatch"},     {15'd0, mis}, {15'd0, e.mis});
        check({who, ".fail"},         {15'd0, fl},  {15'd0, e.fail});
        check({who, ".xz_seen"},      {15'd0, xz},  {15'd0, e.xz});
        check({who, ".err_count"},    err, e.err);
        check({who, ".sample_count"}, smp, e.smp);
        check({who, ".first_a"},      fa, e.fa);
        check({who, ".first_b"},      fb, e.fb);
    endtask

    // One clock: drive at the falling edge, predict, sample 1 ns after the rising edge.
    task automatic cycle(input logic [15:0] a, input logic [15:0] b, input logic e, input logic c);
        exp_t ea, eb;
        o_a = a; o_b = b; en = e; clr = c;
        model_step(0); model_step(1);
        exp_q.push_back(snap(0));
        exp_q.push_back(snap(1));
        @(posedge clk);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        compare_dut("dut_a", ea, st_a, mis_a, fail_a, xz_a, err_a, smp_a, fa_a, fb_a);
        compare_dut("dut_b", eb, st_b, mis_b, fail_b, xz_b, {12'd0, err_b}, {12'd0, smp_b}, fa_b, fb_b);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a_outs"}, {st_a, mis_a, fail_a, xz_a, 11'd0} | err_a | smp_a | fa_a | fb_a, 16'd0);
        check({tag, ".b_outs"}, {st_b, mis_b, fail_b, xz_b, 11'd0} | {12'd0, err_b} | {12'd0, smp_b} | fa_b | fb_b, 16'd0);
    endtask

    initial begin
        logic [15:0] xv;
        logic [15:0] r, fa_first, fb_first;
        xv = 16'h000x;
        rst = 1'b1; en = 1'b0; clr = 1'b0; o_a = '0; o_b = '0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Matching data through warm-up into RUN.
        for (int i = 0; i < 10; i++) cycle(16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
        check("t1.state_run", {14'd0, st_a}, 16'd2);
        check("t1.err_zero", err_a, 16'd0);

        // Single mismatch: budget-1 instance fails, later mismatches ignored.
        cycle(16'h00FF, 16'h00FE, 1'b1, 1'b0);
        check("t2.mismatch", {15'd0, mis_a}, 16'd1);
        check("t2.first_a", fa_a, 16'h00FF);
        check("t2.first_b", fb_a, 16'h00FE);
        check("t2.fail", {15'd0, fail_a}, 16'd1);
        check("t2.state_fail", {14'd0, st_a}, 16'd3);
        cycle(16'h1111, 16'h1111, 1'b1, 1'b0);
        check("t2.pulse_one_cycle", {15'd0, mis_a}, 16'd0);
        for (int i = 0; i < 3; i++) cycle(16'h0F0F, 16'hF0F0, i != 1, 1'b0);
        check("t2.err_held", err_a, 16'd1);

        // X handling after a clear and fresh warm-up.
        cycle(16'h0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(16'h0, 16'h0, 1'b1, 1'b0);
        cycle(xv, 16'h0000, 1'b1, 1'b0);
        cycle(xv, xv, 1'b1, 1'b0);
        cycle(16'h0, 16'h0, 1'b1, 1'b0);
        check("t3.fail_b_low", {15'd0, fail_b}, 16'd0);

        // Saturation on the 4-bit instance with 20 back-to-back mismatches.
        cycle(16'h0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(16'h0, 16'h0, 1'b1, 1'b0);
        fa_first = 16'h0; fb_first = 16'h0;
        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (i == 0) begin fa_first = r; fb_first = r ^ 16'h0101; end
            cycle(r, r ^ 16'h0101, 1'b1, 1'b0);
        end
        check("t4.err_sat", {12'd0, err_b}, 16'h000F);
        check("t4.mis_pulsing", {15'd0, mis_b}, 16'd1);
        check("t4.first_a_held", fa_b, fa_first);
        check("t4.first_b_held", fb_b, fb_first);

        // Clear coinciding with a mismatching sample wins.
        cycle(16'h0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(16'h1234, 16'h4321, 1'b1, 1'b0);
        check("t5.err_three", {12'd0, err_b}, 16'd3);
        cycle(16'h5555, 16'hAAAA, 1'b1, 1'b1);
        check("t5.err_cleared", {12'd0, err_b}, 16'd0);
        check("t5.state_idle", {14'd0, st_b}, 16'd0);

        // Asynchronous reset between edges while in RUN.
        for (int i = 0; i < 5; i++) cycle(16'h00AA, (i == 4) ? 16'h00AB : 16'h00AA, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6.async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(16'h7777, 16'h7777, 1'b1, 1'b0);
        check("t6.resumed_count", smp_a, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
